// File: rtl/bp_trace_checker.sv
// Commit-trace checker: buffers committed register writes and stores, then
// compares them in order against an expected trace until END, a mismatch or a timeout.
module bp_trace_checker #(
  parameter int unsigned dword_width_p    = 64,
  parameter int unsigned reg_addr_width_p = 5,
  parameter int unsigned fifo_els_p       = 4,
  parameter int unsigned timeout_p        = 65536
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          en_i,
  input  logic                          cmt_rd_w_v_i,
  input  logic [reg_addr_width_p-1:0]   cmt_rd_addr_i,
  input  logic                          cmt_mem_w_v_i,
  input  logic [dword_width_p-1:0]      cmt_mem_addr_i,
  input  logic [dword_width_p-1:0]      cmt_data_i,
  input  logic                          trace_v_i,
  input  logic [2+2*dword_width_p-1:0]  trace_data_i,
  output logic                          trace_yumi_o,
  output logic                          done_o,
  output logic                          pass_o,
  output logic                          fail_o,
  output logic [2:0]                    fail_code_o,
  output logic [31:0]                   commit_count_o
);

  localparam int unsigned entry_w = 2 + 2*dword_width_p;
  localparam int unsigned ptr_w   = $clog2(fifo_els_p);

  localparam logic [1:0] kind_reg   = 2'd0;
  localparam logic [1:0] kind_store = 2'd1;
  localparam logic [1:0] kind_end   = 2'd2;
  localparam logic [1:0] kind_rsvd  = 2'd3;

  localparam logic [2:0] fc_none     = 3'd0;
  localparam logic [2:0] fc_mismatch = 3'd1;
  localparam logic [2:0] fc_overflow = 3'd2;
  localparam logic [2:0] fc_bad_end  = 3'd3;
  localparam logic [2:0] fc_timeout  = 3'd4;
  localparam logic [2:0] fc_dual     = 3'd5;
  localparam logic [2:0] fc_rsvd     = 3'd6;

  localparam logic [31:0] timeout_last = 32'(timeout_p - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_PASS,
    S_FAIL
  } state_e;

  state_e state, state_n;

  logic [entry_w-1:0] mem [fifo_els_p];
  logic [ptr_w:0]     wptr, rptr;
  logic               empty, full;
  logic [entry_w-1:0] head, cmt_entry;
  logic [1:0]         trace_kind;
  logic [31:0]        idle_cnt;

  logic               both, enq, pop, end_ok, match, wr_en;
  logic [2:0]         fcode;

  assign empty      = (wptr == rptr);
  assign full       = (wptr[ptr_w] != rptr[ptr_w]) &&
                      (wptr[ptr_w-1:0] == rptr[ptr_w-1:0]);
  assign head       = mem[rptr[ptr_w-1:0]];
  assign trace_kind = trace_data_i[entry_w-1 -: 2];

  always_comb begin
    cmt_entry = {kind_reg, dword_width_p'(cmt_rd_addr_i), cmt_data_i};
    if (cmt_mem_w_v_i)
      cmt_entry = {kind_store, cmt_mem_addr_i, cmt_data_i};
  end

  always_comb begin
    state_n = state;
    both    = 1'b0;
    enq     = 1'b0;
    pop     = 1'b0;
    end_ok  = 1'b0;
    match   = 1'b0;
    fcode   = fc_none;
    case (state)
      S_IDLE: begin
        if (en_i) state_n = S_CHECK;
      end
      S_CHECK: begin
        both   = cmt_rd_w_v_i & cmt_mem_w_v_i;
        enq    = (cmt_rd_w_v_i | cmt_mem_w_v_i) & ~both;
        pop    = trace_v_i & (trace_kind != kind_end) & ~empty;
        end_ok = trace_v_i & (trace_kind == kind_end) & empty & ~enq;
        match  = pop & (head == trace_data_i);
        // Chain ordered by code so the lowest failure code wins.
        if (pop & ~match)                                    fcode = fc_mismatch;
        else if (enq & full & ~pop)                          fcode = fc_overflow;
        else if (trace_v_i & (trace_kind == kind_end) & ~end_ok) fcode = fc_bad_end;
        else if (~enq & (idle_cnt == timeout_last))          fcode = fc_timeout;
        else if (both)                                       fcode = fc_dual;
        else if (trace_v_i & (trace_kind == kind_rsvd))      fcode = fc_rsvd;
        if (fcode != fc_none)  state_n = S_FAIL;
        else if (end_ok)       state_n = S_PASS;
      end
      default: ;
    endcase
  end

  assign trace_yumi_o = pop | end_ok;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign wr_en        = enq & (~full | pop);

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wptr[ptr_w-1:0]] <= cmt_entry;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state          <= S_IDLE;
      wptr           <= '0;
      rptr           <= '0;
      idle_cnt       <= '0;
      commit_count_o <= '0;
      done_o         <= 1'b0;
      pass_o         <= 1'b0;
      fail_o         <= 1'b0;
      fail_code_o    <= '0;
    end else begin
      state <= state_n;
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      if (state == S_CHECK) idle_cnt <= enq ? '0 : idle_cnt + 32'd1;
      if (match) commit_count_o <= commit_count_o + 32'd1;
      if (state == S_CHECK && state_n == S_FAIL) begin
        fail_o      <= 1'b1;
        done_o      <= 1'b1;
        fail_code_o <= fcode;
      end
      if (state == S_CHECK && state_n == S_PASS) begin
        pass_o <= 1'b1;
        done_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_trace_checker.sv
// Bench for bp_trace_checker: directed vector table, hand sequences for
// overflow/timeout/async reset, and random traffic against a queue-based model.
module tb_bp_trace_checker;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned FE = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned EW = 2 + 2*DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, en, rdv, mv, tv;
  logic [AW-1:0] ra;
  logic [DW-1:0] ma, d;
  logic [EW-1:0] td;
  logic          yumi, done, pass, fail;
  logic [2:0]    code;
  logic [31:0]   cnt;

  bp_trace_checker #(
    .dword_width_p(DW),
    .reg_addr_width_p(AW),
    .fifo_els_p(FE),
    .timeout_p(TO)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .en_i(en),
    .cmt_rd_w_v_i(rdv),
    .cmt_rd_addr_i(ra),
    .cmt_mem_w_v_i(mv),
    .cmt_mem_addr_i(ma),
    .cmt_data_i(d),
    .trace_v_i(tv),
    .trace_data_i(td),
    .trace_yumi_o(yumi),
    .done_o(done),
    .pass_o(pass),
    .fail_o(fail),
    .fail_code_o(code),
    .commit_count_o(cnt)
  );

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input bit p, input bit f,
                          input logic [2:0] c, input int unsigned n);
    chk({tag, " pass"},  64'(pass), 64'(p));
    chk({tag, " fail"},  64'(fail), 64'(f));
    chk({tag, " done"},  64'(done), 64'(p | f));
    chk({tag, " code"},  64'(code), 64'(c));
    chk({tag, " count"}, 64'(cnt),  64'(n));
  endtask

  function automatic logic [EW-1:0] te(input logic [1:0] k, input logic [DW-1:0] a,
                                       input logic [DW-1:0] dd);
    return {k, a, dd};
  endfunction

  task automatic quiet();
    rdv = 1'b0; mv = 1'b0; tv = 1'b0;
    ra = '0; ma = '0; d = '0; td = '0;
  endtask

  // Called just after a rising edge; reset is pulsed entirely between edges.
  task automatic do_reset();
    reset_n = 1'b0;
    en = 1'b0;
    quiet();
    #2;
    reset_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            rst;
    bit            en;
    bit            rdv;
    logic [AW-1:0] ra;
    bit            mv;
    logic [DW-1:0] ma;
    logic [DW-1:0] d;
    bit            tv;
    logic [EW-1:0] td;
    bit            y;
    bit            p;
    bit            f;
    logic [2:0]    c;
    int unsigned   n;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit rst, input bit e, input bit r_v, input logic [AW-1:0] r_a,
                              input bit m_v, input logic [DW-1:0] m_a, input logic [DW-1:0] dat,
                              input bit t_v, input logic [EW-1:0] t_d, input bit y, input bit p,
                              input bit f, input logic [2:0] c, input int unsigned n);
    vec_t v;
    v.rst = rst; v.en = e; v.rdv = r_v; v.ra = r_a; v.mv = m_v; v.ma = m_a; v.d = dat;
    v.tv = t_v; v.td = t_d; v.y = y; v.p = p; v.f = f; v.c = c; v.n = n;
    vecs.push_back(v);
  endfunction

  task automatic apply(input int lo, input int hi, input bit allow_rst);
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].rst && allow_rst) do_reset();
      en = vecs[i].en; rdv = vecs[i].rdv; ra = vecs[i].ra; mv = vecs[i].mv;
      ma = vecs[i].ma; d = vecs[i].d; tv = vecs[i].tv; td = vecs[i].td;
      #1;
      chk($sformatf("v%0d yumi", i), 64'(yumi), 64'(vecs[i].y));
      tick();
      chk_outs($sformatf("v%0d", i), vecs[i].p, vecs[i].f, vecs[i].c, vecs[i].n);
    end
  endtask

  // ---------------- reference model ----------------
  logic [EW-1:0] mq[$];
  int            m_ph;    // 0 idle, 1 checking, 2 passed, 3 failed
  int unsigned   m_idle;
  int unsigned   m_cnt;
  logic [2:0]    m_code;

  task automatic model_reset();
    mq.delete();
    m_ph = 0; m_idle = 0; m_cnt = 0; m_code = '0;
  endtask

  task automatic model_step(output bit ey);
    bit both, enq, pop, endok, match, found;
    logic [1:0] k;
    bit [6:1] fl;
    ey = 1'b0;
    if (m_ph == 0) begin
      if (en) m_ph = 1;
    end else if (m_ph == 1) begin
      k     = td[EW-1 -: 2];
      both  = rdv && mv;
      enq   = (rdv || mv) && !both;
      pop   = tv && k != 2'd2 && mq.size() != 0;
      endok = tv && k == 2'd2 && mq.size() == 0 && !enq;
      ey    = pop || endok;
      match = 1'b0;
      if (pop) match = (mq[0] == td);
      fl    = '0;
      fl[1] = pop && !match;
      fl[2] = enq && mq.size() == FE && !pop;
      fl[3] = tv && k == 2'd2 && !endok;
      fl[4] = !enq && m_idle == TO - 1;
      fl[5] = both;
      fl[6] = tv && k == 2'd3;
      if (match) m_cnt++;
      if (pop) void'(mq.pop_front());
      if (enq && mq.size() < FE)
        mq.push_back(mv ? {2'd1, ma, d} : {2'd0, {(DW-AW){1'b0}}, ra, d});
      m_idle = enq ? 0 : m_idle + 1;
      found = 1'b0;
      for (int i = 1; i <= 6; i++)
        if (fl[i] && !found) begin
          found = 1'b1;
          m_code = 3'(i);
        end
      if (found)      m_ph = 3;
      else if (endok) m_ph = 2;
    end
  endtask

  task automatic rand_inputs();
    int r;
    int idx;
    r = int'($urandom_range(0, 99));
    rdv = 1'b0; mv = 1'b0;
    if (r < 30)      rdv = 1'b1;
    else if (r < 50) mv = 1'b1;
    else if (r < 52) begin rdv = 1'b1; mv = 1'b1; end
    ra = AW'($urandom);
    ma = {$urandom, $urandom};
    d  = {32'($urandom_range(0, 3)), $urandom};
    if (m_ph == 0) en = ($urandom_range(0, 3) != 0);
    tv = ($urandom_range(0, 99) < 45);
    r  = int'($urandom_range(0, 99));
    if (mq.size() != 0 && r < 90) begin
      td = mq[0];
      if (r < 4) begin
        idx = int'($urandom_range(0, EW - 1));
        td[idx] = ~td[idx];
      end
    end else if (mq.size() == 0 && r < 35) td = te(2'd2, '0, '0);
    else if (r < 38) td = te(2'd3, '0, '0);
    else td = te(2'(($urandom_range(0, 1))), {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ey;
    int extra;

    // A: REQ-038 pass path (vecs 0..5); trace END during IDLE is not consumed
    add(1,1, 0,5'd0, 0,64'h0,        64'h0,    1,te(2,0,0),                0,0,0,0,0);
    add(0,1, 1,5'd5, 0,64'h0,        64'h1234, 0,'0,                       0,0,0,0,0);
    add(0,1, 0,5'd0, 1,64'h8000_0000,64'hDEAD, 1,te(0,5,64'h1234),         1,0,0,0,1);
    add(0,1, 0,5'd0, 0,64'h0,        64'h0,    1,te(1,64'h8000_0000,64'hDEAD),1,0,0,0,2);
    add(0,1, 0,5'd0, 0,64'h0,        64'h0,    1,te(2,0,0),                1,1,0,0,2);
    add(0,1, 1,5'd7, 0,64'h0,        64'h9,    1,te(0,7,9),                0,1,0,0,2);
    // B: REQ-039 data mismatch (vecs 6..9)
    add(1,1, 0,5'd0, 0,64'h0, 64'h0,    0,'0,                0,0,0,0,0);
    add(0,0, 1,5'd5, 0,64'h0, 64'h1234, 0,'0,                0,0,0,0,0);
    add(0,0, 0,5'd0, 0,64'h0, 64'h0,    1,te(0,5,64'h1235),  1,0,1,1,0);
    add(0,0, 0,5'd0, 0,64'h0, 64'h0,    1,te(0,5,64'h1235),  0,0,1,1,0);
    // C: REQ-041 END with same-cycle commit (vecs 10..11)
    add(1,1, 0,5'd0, 0,64'h0, 64'h0,  0,'0,         0,0,0,0,0);
    add(0,1, 1,5'd1, 0,64'h0, 64'hAA, 1,te(2,0,0),  0,0,1,3,0);
    // D: reserved kind on empty FIFO (vecs 12..13)
    add(1,1, 0,5'd0, 0,64'h0, 64'h0, 0,'0,         0,0,0,0,0);
    add(0,1, 0,5'd0, 0,64'h0, 64'h0, 1,te(3,0,0),  0,0,1,6,0);
    // E: register write and store in one cycle (vecs 14..15)
    add(1,1, 0,5'd0, 0,64'h0,  64'h0, 0,'0, 0,0,0,0,0);
    add(0,1, 1,5'd2, 1,64'h10, 64'h1, 0,'0, 0,0,1,5,0);
    // F: full FIFO with simultaneous pop and push, then drain and END (vecs 16..26)
    add(1,1, 0,5'd0, 0,64'h0, 64'h0,  0,'0,          0,0,0,0,0);
    add(0,1, 1,5'd1, 0,64'h0, 64'h11, 0,'0,          0,0,0,0,0);
    add(0,1, 1,5'd2, 0,64'h0, 64'h22, 0,'0,          0,0,0,0,0);
    add(0,1, 1,5'd3, 0,64'h0, 64'h33, 0,'0,          0,0,0,0,0);
    add(0,1, 1,5'd4, 0,64'h0, 64'h44, 0,'0,          0,0,0,0,0);
    add(0,1, 1,5'd6, 0,64'h0, 64'h66, 1,te(0,1,64'h11), 1,0,0,0,1);
    add(0,1, 0,5'd0, 0,64'h0, 64'h0,  1,te(0,2,64'h22), 1,0,0,0,2);
    add(0,1, 0,5'd0, 0,64'h0, 64'h0,  1,te(0,3,64'h33), 1,0,0,0,3);
    add(0,1, 0,5'd0, 0,64'h0, 64'h0,  1,te(0,4,64'h44), 1,0,0,0,4);
    add(0,1, 0,5'd0, 0,64'h0, 64'h0,  1,te(0,6,64'h66), 1,0,0,0,5);
    add(0,1, 0,5'd0, 0,64'h0, 64'h0,  1,te(2,0,0),      1,1,0,0,5);
    // G: kind alone differs (store vs expected register write) (vecs 27..29)
    add(1,1, 0,5'd0, 0,64'h0, 64'h0,    0,'0,               0,0,0,0,0);
    add(0,1, 0,5'd0, 1,64'h5, 64'h1234, 0,'0,               0,0,0,0,0);
    add(0,1, 0,5'd0, 0,64'h0, 64'h0,    1,te(0,5,64'h1234), 1,0,1,1,0);
    // H: mismatch and dual commit together -> lowest code (vecs 30..32)
    add(1,1, 0,5'd0, 0,64'h0, 64'h0, 0,'0,         0,0,0,0,0);
    add(0,1, 1,5'd1, 0,64'h0, 64'h1, 0,'0,         0,0,0,0,0);
    add(0,1, 1,5'd1, 1,64'h8, 64'h1, 1,te(0,1,2),  1,0,1,1,0);

    reset_n = 1'b0;
    en = 1'b0;
    quiet();
    repeat (2) @(posedge clk);
    #1;
    chk("reset yumi", 64'(yumi), 64'd0);
    chk_outs("reset", 0, 0, 3'd0, 0);

    apply(0, vecs.size() - 1, 1'b1);

    // REQ-040: five back-to-back commits overflow a four-deep FIFO
    do_reset();
    en = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) begin
      rdv = 1'b1; ra = AW'(i); d = 64'(i);
      tick();
      chk_outs($sformatf("ovf c%0d", i), 0, (i == 5), (i == 5) ? 3'd2 : 3'd0, 0);
    end
    quiet();

    // REQ-042: no commits at all -> timeout
    do_reset();
    en = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      tick();
      if (k == 15 || k == 16)
        chk_outs($sformatf("tmo k%0d", k), 0, (k == 16), (k == 16) ? 3'd4 : 3'd0, 0);
    end

    // REQ-043: async reset with entries buffered, then the pass scenario again
    do_reset();
    en = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      rdv = 1'b1; ra = AW'(i); d = 64'(i * 16);
      tv = (i == 4);
      td = te(0, 64'd1, 64'd16);
      tick();
    end
    quiet();
    chk("pre-rst count", 64'(cnt), 64'd1);
    tv = 1'b1;
    td = te(0, 64'd2, 64'd32);
    #1;
    chk("pre-rst yumi", 64'(yumi), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("async rst yumi", 64'(yumi), 64'd0);
    chk_outs("async rst", 0, 0, 3'd0, 0);
    quiet();
    en = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();
    chk_outs("post rst idle", 0, 0, 3'd0, 0);
    apply(0, 5, 1'b0);

    // Random traffic against the model
    for (int run = 0; run < 60; run++) begin
      do_reset();
      model_reset();
      extra = 0;
      for (int c = 0; c < 80 && extra < 3; c++) begin
        rand_inputs();
        model_step(ey);
        #1;
        chk($sformatf("rnd%0d.%0d yumi", run, c), 64'(yumi), 64'(ey));
        tick();
        chk_outs($sformatf("rnd%0d.%0d", run, c), (m_ph == 2), (m_ph == 3),
                 (m_ph == 3) ? m_code : 3'd0, m_cnt);
        if (m_ph >= 2) extra++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bp_trace_checker.md
BP_TRACE_CHECKER -- requirements
Module: bp_trace_checker

Interface
REQ-001 Parameter dword_width_p, default 64, width of the commit address and data fields.
REQ-002 Parameter reg_addr_width_p, default 5, width of the register-file address.
REQ-003 Parameter fifo_els_p, default 4, commit-buffer depth; power of two, at least 2.
REQ-004 Parameter timeout_p, default 65536, number of consecutive commit-free cycles in CHECK that are tolerated.
REQ-005 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n_i  in  1  asynchronous, active-low reset.
REQ-007 en_i  in  1  start checking (level-sensitive).
REQ-008 cmt_rd_w_v_i  in  1  core committed a register write this cycle.
REQ-009 cmt_rd_addr_i  in  reg_addr_width_p  register address of the committed write.
REQ-010 cmt_mem_w_v_i  in  1  core committed a store this cycle.
REQ-011 cmt_mem_addr_i  in  dword_width_p  store address.
REQ-012 cmt_data_i  in  dword_width_p  register-write data or store data.
REQ-013 trace_v_i  in  1  expected-trace entry valid.
REQ-014 trace_data_i  in  2+2*dword_width_p  expected entry {kind[1:0], addr, data}; kind 0 = register write, 1 = store, 2 = end, 3 = reserved.
REQ-015 trace_yumi_o  out  1  consumes trace_data_i in the same cycle.
REQ-016 done_o, pass_o, fail_o  out  1 each  sticky completion status.
REQ-017 fail_code_o  out  3  failure reason.
REQ-018 commit_count_o  out  32  number of matched commits.

Function
REQ-019 State machine has four states: IDLE, CHECK, PASS, FAIL; IDLE->CHECK in the cycle after en_i=1; PASS and FAIL are terminal until reset.
REQ-020 Commit events are captured only in CHECK, never back-pressured, and enqueued the same cycle into a FIFO of fifo_els_p entries as {kind, addr, data}.
REQ-021 Register-write event: kind=0, addr = zero-extended cmt_rd_addr_i; store event: kind=1, addr = cmt_mem_addr_i.
REQ-022 cmt_rd_w_v_i and cmt_mem_w_v_i both 1 in one cycle -> FAIL, code 5; nothing is enqueued.
REQ-023 Enqueue while the FIFO is full with no same-cycle pop -> FAIL, code 2.
REQ-024 Full FIFO with a same-cycle pop and enqueue -> legal; occupancy unchanged.
REQ-025 Compare step, in CHECK with trace_v_i=1: if FIFO non-empty and kind!=2, trace_yumi_o=1 and the head is popped.
REQ-026 Match requires equal kind, full addr and full data; on match commit_count_o increments by 1 (wraps at 2^32).
REQ-027 Compare with FIFO non-empty and kind!=2 that does not match -> FAIL, code 1.
REQ-028 Trace kind=2 with FIFO empty and no same-cycle enqueue -> trace_yumi_o=1 and the next state is PASS.
REQ-029 Trace kind=2 with FIFO non-empty or a same-cycle enqueue -> FAIL, code 3.
REQ-030 Trace kind=3 -> FAIL, code 6.
REQ-031 trace_yumi_o=0 outside CHECK, and 0 when the FIFO is empty and kind!=2.
REQ-032 Commit-free counter resets on every enqueue and increments otherwise in CHECK; reaching timeout_p-1 -> FAIL, code 4.
REQ-033 Multiple failure conditions in one cycle -> lowest code wins.
REQ-034 Outputs are registered: done_o = pass_o | fail_o; in PASS fail_code_o=0; fail_code_o holds its value in FAIL.
REQ-035 Commits arriving in PASS or FAIL are ignored; commit_count_o freezes.

Reset
REQ-036 reset_n_i=0 asynchronously forces IDLE, an empty FIFO, counters=0, done_o=pass_o=fail_o=0, fail_code_o=0, trace_yumi_o=0.
REQ-037 Reset asserted mid-operation discards all buffered commits; after deassertion the block waits for en_i again.

Verification
REQ-038 en_i=1; commit rd x5=0x1234, then a store to 0x8000_0000 with data 0xDEAD; trace supplies the matching two entries then END -> pass_o=1, commit_count_o=2, fail_code_o=0.
REQ-039 Commit rd x5=0x1234; trace expects x5=0x1235 -> fail_o=1, fail_code_o=1, commit_count_o=0.
REQ-040 fifo_els_p=4; trace_v_i held 0; 5 commits on consecutive cycles -> fail_code_o=2 the cycle after the 5th commit.
REQ-041 Commit rd x1 and trace END presented in the same cycle -> fail_code_o=3.
REQ-042 timeout_p=16; en_i=1 with no commits -> fail_code_o=4 after 16 cycles.
REQ-043 Assert reset_n_i=0 with 3 entries buffered -> all outputs 0 immediately; rerun scenario REQ-038 -> passes.
